maj7_tt_sweeper: RTL

MAJ7_TT_SWEEPER -- requirements
Module: maj7_tt_sweeper

---
 rtl/maj7_pkg.sv | 27 ++
 rtl/maj7_tt_sweeper_if.sv | 34 +++
 rtl/maj7_lat_pipe.sv | 42 ++++
 rtl/maj7_tt_sweeper.sv | 98 +++++++++
 4 files changed

// File: rtl/maj7_pkg.sv
// Shared constants, FSM state type and pipeline tap type for the
// 7-input truth-table sweeper.
package maj7_pkg;
  localparam int N_IN    = 7;
  localparam int TT_W    = 128;
  localparam int LAT_MAX = 3;
  localparam int ONES_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // one entry of the index delay line: which truth-table bit the FUT
  // response belongs to, and whether it is a real sample
  typedef struct packed {
    logic            vld;
    logic [N_IN-1:0] idx;
  } tap_t;

  // terminal count of the vector counter
  function automatic logic is_last(input logic [N_IN-1:0] v);
    return &v;
  endfunction
endpackage

// File: rtl/maj7_tt_sweeper_if.sv
// Host/FUT-facing bundle of the sweeper. master = host + FUT side,
// slave = sweeper. ones_count exists only with MAJ7_TT_POPCOUNT_EN.
interface maj7_tt_sweeper_if;
  import maj7_pkg::*;

  logic            start;
  logic            abort;
  logic [TT_W-1:0] tt_expected;
  logic [N_IN-1:0] vec_out;
  logic            fut_out;
  logic            busy;
  logic            done;
  logic [TT_W-1:0] tt;
  logic            match;
`ifdef MAJ7_TT_POPCOUNT_EN
  logic [ONES_W-1:0] ones_count;
`endif

  modport master (
    output start, abort, tt_expected, fut_out,
    input  vec_out, busy, done, tt, match
`ifdef MAJ7_TT_POPCOUNT_EN
    , input ones_count
`endif
  );

  modport slave (
    input  start, abort, tt_expected, fut_out,
    output vec_out, busy, done, tt, match
`ifdef MAJ7_TT_POPCOUNT_EN
    , output ones_count
`endif
  );
endinterface

// File: rtl/maj7_lat_pipe.sv
// LAT-deep delay line for the (valid, index) tap, so each FUT response
// lands on the truth-table bit of the vector that produced it.
// LAT = 0 is a straight wire.
module maj7_lat_pipe import maj7_pkg::*; #(
  parameter int LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  tap_t tap,
  output tap_t tap_d
);
  generate
    if (LAT == 0) begin : g_bypass
      // clock and flush have no work to do without stages
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst, flush};
      assign tap_d = tap;
    end else begin : g_pipe
      logic [LAT:1]           vld_pipe;
      logic [LAT:1][N_IN-1:0] idx_pipe;

      // shift one stage per clock; flush drops everything in flight
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          vld_pipe <= '0;
          idx_pipe <= '0;
        end else begin
          vld_pipe[1] <= tap.vld;
          idx_pipe[1] <= tap.idx;
          for (int i = 2; i <= LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            idx_pipe[i] <= idx_pipe[i-1];
          end
        end
      end

      assign tap_d.vld = vld_pipe[LAT];
      assign tap_d.idx = idx_pipe[LAT];
    end
  endgenerate
endmodule

// File: rtl/maj7_tt_sweeper.sv
// Truth-table sweeper: drives all 128 input vectors to a 7-input FUT,
// collects its responses (LAT cycles behind) into tt and compares the
// result against a golden table captured at start.
// Optional: define MAJ7_TT_POPCOUNT_EN to add the ones_count output.
module maj7_tt_sweeper import maj7_pkg::*; #(
  parameter int N_IN = maj7_pkg::N_IN,
  parameter int LAT  = 0
) (
  input logic               clk,
  input logic               rst,
  maj7_tt_sweeper_if.slave  bus
);
  state_t          state, state_nxt;
  logic [N_IN-1:0] cnt;
  logic [TT_W-1:0] tt_q, exp_q;
  logic            done_q;
  logic            go, last, clr;
  tap_t            tap, tap_d;

  // start is only honoured when idle or finished, and abort beats it
  assign go   = bus.start && !bus.abort && (state == ST_IDLE || state == ST_DONE);
  assign last = (state == ST_SWEEP) && is_last(cnt);
  assign clr  = bus.abort || go;

  maj7_lat_pipe #(.LAT(LAT)) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .flush (clr),
    .tap   (tap),
    .tap_d (tap_d)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next state and combinational outputs; DRAIN ends on the last write
  always_comb begin
    state_nxt   = state;
    bus.busy    = (state == ST_SWEEP) || (state == ST_DRAIN);
    bus.vec_out = (state == ST_SWEEP) ? cnt : '0;
    bus.match   = (state == ST_DONE) && (tt_q == exp_q);
    tap.vld     = (state == ST_SWEEP);
    tap.idx     = cnt;
    if (bus.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE,
        ST_DONE:  if (bus.start) state_nxt = ST_SWEEP;
        ST_SWEEP: if (last) state_nxt = (LAT == 0) ? ST_DONE : ST_DRAIN;
        ST_DRAIN: if (tap_d.vld && is_last(tap_d.idx)) state_nxt = ST_DONE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // vector counter; parks at 0 after terminal count instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr)              cnt <= '0;
    else if (state == ST_SWEEP)  cnt <= last ? '0 : cnt + 1'b1;
  end

  // truth-table capture at the delayed index
  always_ff @(posedge clk) begin
    if (rst || clr)     tt_q <= '0;
    else if (tap_d.vld) tt_q[tap_d.idx] <= bus.fut_out;
  end

  // golden table latched on an accepted start
  always_ff @(posedge clk) begin
    if (rst)     exp_q <= '0;
    else if (go) exp_q <= bus.tt_expected;
  end

  // single-cycle done on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= (state_nxt == ST_DONE) && (state != ST_DONE);
  end

  assign bus.done = done_q;
  assign bus.tt   = tt_q;

`ifdef MAJ7_TT_POPCOUNT_EN
  logic [ONES_W-1:0] ones_q;

  // running count of 1 bits; each bit is written once per sweep
  always_ff @(posedge clk) begin
    if (rst || clr)                    ones_q <= '0;
    else if (tap_d.vld && bus.fut_out) ones_q <= ones_q + 1'b1;
  end

  assign bus.ones_count = ones_q;
`endif
endmodule
